conv_result_streamer: RTL and testbench

- Consumer-side companion to the 3x3 convolution engine.
- On a request it starts the engine by holding its start line, waits for its done, then releases start so the engine returns to idle.
- It then walks the engine's combinational result read port (address in, data out same cycle) from index 0 to OUT_N-1.
- Each result goes out on a valid/ready stream toward the UART/display path, at one word per cycle when the sink never stalls. The engine's cycle count is latched for reporting.

---
 rtl/conv_result_streamer.sv | 166 ++++++++++++++++
 tb/tb_conv_result_streamer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_streamer.sv
// Runs one 3x3 convolution on request, then streams the engine's OUT_N result
// words over a valid/ready interface and reports the engine's cycle count.
module conv_result_streamer #(
    parameter int unsigned OUT_N   = 80,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              busy,
    output logic              conv_start,
    input  logic              conv_done,
    input  logic [31:0]       conv_cycles,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_last,
    output logic [31:0]       cycles_latched,
    output logic              fin,
    output logic              timeout_err
);

    localparam int unsigned       WD_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_N - 1);
    localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_RELEASE,
        S_STREAM,
        S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                conv_start_q, conv_start_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [ADDR_W-1:0]   m_index_q, m_index_d;
    logic                m_last_q, m_last_d;
    logic [31:0]         cycles_q, cycles_d;
    logic                fin_q, fin_d;
    logic                timeout_err_q, timeout_err_d;
    logic [WD_W-1:0]     wd_q, wd_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        conv_start_d  = conv_start_q;
        rd_addr_d     = rd_addr_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_index_d     = m_index_q;
        m_last_d      = m_last_q;
        cycles_d      = cycles_q;
        fin_d         = 1'b0;
        timeout_err_d = timeout_err_q;
        wd_d          = wd_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d       = S_CONV;
                    busy_d        = 1'b1;
                    conv_start_d  = 1'b1;
                    timeout_err_d = 1'b0;
                    wd_d          = '0;
                    rd_addr_d     = '0;
                end
            end
            S_CONV: begin
                // A done already high on entry is taken as completion
                if (conv_done) begin
                    cycles_d     = conv_cycles;
                    conv_start_d = 1'b0;
                    state_d      = S_RELEASE;
                end else if (wd_q == WD_LIMIT) begin
                    conv_start_d  = 1'b0;
                    timeout_err_d = 1'b1;
                    fin_d         = 1'b1;
                    state_d       = S_FIN;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_RELEASE: begin
                rd_addr_d = '0;
                m_valid_d = 1'b0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                if (m_valid_q && m_ready && m_last_q) begin
                    m_valid_d = 1'b0;
                    fin_d     = 1'b1;
                    state_d   = S_FIN;
                end else if (!m_valid_q || m_ready) begin
                    // Output register empty or being drained: pull the next word
                    m_data_d  = rd_data;
                    m_index_d = rd_addr_q;
                    m_last_d  = (rd_addr_q == LAST_ADDR);
                    m_valid_d = 1'b1;
                    if (rd_addr_q != LAST_ADDR) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            conv_start_q  <= 1'b0;
            rd_addr_q     <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_index_q     <= '0;
            m_last_q      <= 1'b0;
            cycles_q      <= '0;
            fin_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            conv_start_q  <= conv_start_d;
            rd_addr_q     <= rd_addr_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_index_q     <= m_index_d;
            m_last_q      <= m_last_d;
            cycles_q      <= cycles_d;
            fin_q         <= fin_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
        end
    end

    assign busy           = busy_q;
    assign conv_start     = conv_start_q;
    assign rd_addr        = rd_addr_q;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;
    assign m_index        = m_index_q;
    assign m_last         = m_last_q;
    assign cycles_latched = cycles_q;
    assign fin            = fin_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Bench for conv_result_streamer: engine model with result memory, sink with
// configurable ready patterns, and a second instance with a short timeout.
module tb_conv_result_streamer;

    localparam int unsigned OUT_N  = 80;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance
    logic              req, busy, conv_start, conv_done;
    logic [31:0]       conv_cycles, cycles_latched;
    logic [ADDR_W-1:0] rd_addr, m_index;
    logic [DATA_W-1:0] rd_data, m_data;
    logic              m_valid, m_ready, m_last, fin, timeout_err;

    // Timeout instance (engine never finishes)
    logic              t_req, t_busy, t_conv_start, t_conv_done;
    logic [31:0]       t_conv_cycles, t_cycles_latched;
    logic [ADDR_W-1:0] t_rd_addr, t_m_index;
    logic [DATA_W-1:0] t_rd_data, t_m_data;
    logic              t_m_valid, t_m_ready, t_m_last, t_fin, t_timeout_err;

    logic signed [DATA_W-1:0] mem [128];
    assign rd_data = mem[rd_addr];

    conv_result_streamer #(.OUT_N(OUT_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4096)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .busy(busy), .conv_start(conv_start),
        .conv_done(conv_done), .conv_cycles(conv_cycles), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .cycles_latched(cycles_latched), .fin(fin), .timeout_err(timeout_err)
    );

    conv_result_streamer #(.OUT_N(OUT_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(64)) dut_to (
        .clk(clk), .rst_n(rst_n), .req(t_req), .busy(t_busy), .conv_start(t_conv_start),
        .conv_done(t_conv_done), .conv_cycles(t_conv_cycles), .rd_addr(t_rd_addr), .rd_data(t_rd_data),
        .m_valid(t_m_valid), .m_ready(t_m_ready), .m_data(t_m_data), .m_index(t_m_index),
        .m_last(t_m_last), .cycles_latched(t_cycles_latched), .fin(t_fin), .timeout_err(t_timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Engine model: raises done after done_delay cycles of start, drops it when start falls
    int done_delay = 1000000;
    int eng_cnt = 0;
    initial begin
        conv_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (conv_start) begin
                eng_cnt++;
                if (eng_cnt >= done_delay) conv_done = 1'b1;
            end else begin
                eng_cnt   = 0;
                conv_done = 1'b0;
            end
        end
    end

    // Observations of one transaction
    logic signed [DATA_W-1:0] got_data [$];
    int  got_idx [$];
    bit  got_last [$];
    int  first_hs, last_hs, cs_cycles, fin_cnt, fin_at, stall_viol;

    task automatic fill_mem();
        for (int i = 0; i < 128; i++) mem[i] = DATA_W'($urandom);
        mem[0]  = 0;
        mem[3]  = -5;
        mem[10] = 32'h7FFF_FFFF;
        mem[79] = 32'h8000_0000;
    endtask

    // Drives one request and records the stream; mode 0: ready=1, 1: 1-0-0-1, 2: random
    task automatic run_stream(input int mode, input int req_at, input int max_cyc);
        bit pend = 1'b0;
        bit req_sent = 1'b0;
        logic [DATA_W-1:0] pd = '0;
        logic [ADDR_W-1:0] pi = '0;
        logic pl = 1'b0;
        got_data.delete(); got_idx.delete(); got_last.delete();
        first_hs = -1; last_hs = -1; cs_cycles = 0; fin_cnt = 0; fin_at = -1; stall_viol = 0;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (c % 4 == 0) || (c % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            req = (req_at >= 0 && !req_sent && got_data.size() == req_at && m_valid);
            if (req) req_sent = 1'b1;
            if (conv_start) cs_cycles++;
            if (pend && (!m_valid || m_data !== pd || m_index !== pi || m_last !== pl)) stall_viol++;
            pend = m_valid && !m_ready;
            pd = m_data; pi = m_index; pl = m_last;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_idx.push_back(int'(m_index));
                got_last.push_back(m_last);
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            if (fin) begin
                fin_cnt++;
                if (fin_at < 0) fin_at = c;
            end
            if (fin_at >= 0 && c >= fin_at + 3) break;
            @(negedge clk);
        end
        req = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, conv_start, rd_addr, m_valid, m_data, m_index, m_last, cycles_latched, fin, timeout_err} !== 84'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b start=%b addr=%0d valid=%b data=%h idx=%0d last=%b cyc=%0d fin=%b err=%b, expected all 0",
                     busy, conv_start, rd_addr, m_valid, m_data, m_index, m_last, cycles_latched, fin, timeout_err);
        end
        checks++;
        if ({t_busy, t_conv_start, t_rd_addr, t_m_valid, t_m_data, t_m_index, t_m_last, t_cycles_latched, t_fin, t_timeout_err} !== 84'd0) begin
            errors++;
            $display("FAIL reset_outputs_to: got busy=%b start=%b err=%b fin=%b, expected all 0", t_busy, t_conv_start, t_timeout_err, t_fin);
        end
    endtask

    task automatic test_basic();
        fill_mem();
        done_delay = 720; conv_cycles = 720;
        run_stream(0, -1, 2000);
        checks++;
        if (cs_cycles != 720) begin errors++; $display("FAIL basic_start_len: got %0d cycles, expected 720", cs_cycles); end
        checks++;
        if (cycles_latched !== 32'd720) begin errors++; $display("FAIL basic_cycles_latched: got %0d, expected 720", cycles_latched); end
        checks++;
        // one RELEASE cycle, one cycle into STREAM, then first word
        if (first_hs != 722) begin errors++; $display("FAIL basic_first_word: got cycle %0d, expected 722", first_hs); end
        checks++;
        if (last_hs - first_hs != OUT_N - 1) begin errors++; $display("FAIL basic_back_to_back: got span %0d, expected %0d", last_hs - first_hs, OUT_N - 1); end
        checks++;
        if (fin_cnt != 1) begin errors++; $display("FAIL basic_fin_count: got %0d, expected 1", fin_cnt); end
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got busy=%b valid=%b, expected 0 0", busy, m_valid); end
        checks++;
        if (got_data.size() != OUT_N) begin errors++; $display("FAIL basic_word_count: got %0d, expected %0d", got_data.size(), OUT_N); end
        for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
            checks++;
            if (got_data[i] !== mem[i] || got_idx[i] != i || got_last[i] !== (i == OUT_N - 1)) begin
                errors++;
                $display("FAIL basic_word[%0d]: got data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                         i, got_data[i], got_idx[i], got_last[i], mem[i], i, (i == OUT_N - 1));
            end
        end
    endtask

    task automatic test_backpressure();
        fill_mem();
        done_delay = 50; conv_cycles = 50;
        run_stream(1, -1, 2000);
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalled cycles, expected 0", stall_viol); end
        checks++;
        if (fin_cnt != 1) begin errors++; $display("FAIL bp_fin_count: got %0d, expected 1", fin_cnt); end
        checks++;
        if (got_data.size() != OUT_N) begin errors++; $display("FAIL bp_word_count: got %0d, expected %0d", got_data.size(), OUT_N); end
        for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
            checks++;
            if (got_data[i] !== mem[i] || got_idx[i] != i || got_last[i] !== (i == OUT_N - 1)) begin
                errors++;
                $display("FAIL bp_word[%0d]: got data=%h idx=%0d last=%b, expected data=%h idx=%0d last=%b",
                         i, got_data[i], got_idx[i], got_last[i], mem[i], i, (i == OUT_N - 1));
            end
        end
    endtask

    task automatic test_req_while_busy();
        fill_mem();
        done_delay = 40; conv_cycles = 40;
        run_stream(0, 30, 2000);
        checks++;
        if (cs_cycles != 40) begin errors++; $display("FAIL busyreq_start_len: got %0d cycles, expected 40", cs_cycles); end
        checks++;
        if (fin_cnt != 1) begin errors++; $display("FAIL busyreq_fin_count: got %0d, expected 1", fin_cnt); end
        checks++;
        if (busy !== 1'b0 || conv_start !== 1'b0) begin errors++; $display("FAIL busyreq_idle_after: got busy=%b start=%b, expected 0 0", busy, conv_start); end
        checks++;
        if (got_data.size() != OUT_N) begin errors++; $display("FAIL busyreq_word_count: got %0d, expected %0d", got_data.size(), OUT_N); end
        for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
            checks++;
            if (got_data[i] !== mem[i] || got_idx[i] != i || got_last[i] !== (i == OUT_N - 1)) begin
                errors++;
                $display("FAIL busyreq_word[%0d]: got data=%h idx=%0d, expected data=%h idx=%0d", i, got_data[i], got_idx[i], mem[i], i);
            end
        end
    endtask

    task automatic test_timeout();
        int cs = 0, fins = 0, vals = 0;
        bit dropped = 1'b0;
        logic fin_at_drop = 1'b0, err_at_drop = 1'b0;
        @(negedge clk); t_req = 1'b1;
        @(negedge clk); t_req = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (t_conv_start) cs++;
            else if (!dropped) begin
                dropped = 1'b1; fin_at_drop = t_fin; err_at_drop = t_timeout_err;
            end
            if (t_fin) fins++;
            if (t_m_valid) vals++;
            @(negedge clk);
        end
        checks++;
        if (cs != 64) begin errors++; $display("FAIL to_start_len: got %0d cycles, expected 64", cs); end
        checks++;
        if (fin_at_drop !== 1'b1 || err_at_drop !== 1'b1) begin errors++; $display("FAIL to_abort: got fin=%b err=%b, expected 1 1", fin_at_drop, err_at_drop); end
        checks++;
        if (fins != 1 || vals != 0) begin errors++; $display("FAIL to_pulses: got fin=%0d valid=%0d, expected 1 0", fins, vals); end
        checks++;
        if (t_timeout_err !== 1'b1 || t_busy !== 1'b0) begin errors++; $display("FAIL to_sticky: got err=%b busy=%b, expected 1 0", t_timeout_err, t_busy); end
        t_req = 1'b1;
        @(negedge clk); t_req = 1'b0;
        checks++;
        if (t_timeout_err !== 1'b0 || t_busy !== 1'b1) begin errors++; $display("FAIL to_clear: got err=%b busy=%b, expected 0 1", t_timeout_err, t_busy); end
        repeat (80) @(negedge clk);
    endtask

    task automatic test_reset_mid_stream();
        bit found = 1'b0;
        fill_mem();
        done_delay = 100; conv_cycles = 100;
        m_ready = 1'b1;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (m_valid && m_index == ADDR_W'(40)) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_reach_40: got no index 40, expected it within 1000 cycles"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, conv_start, rd_addr, m_valid, m_data, m_index, m_last, cycles_latched, fin, timeout_err} !== 84'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got busy=%b start=%b addr=%0d valid=%b idx=%0d cyc=%0d, expected all 0",
                     busy, conv_start, rd_addr, m_valid, m_index, cycles_latched);
        end
        @(negedge clk); rst_n = 1'b1;
        fill_mem();
        run_stream(0, -1, 2000);
        checks++;
        if (got_data.size() != OUT_N || got_idx[0] != 0) begin
            errors++;
            $display("FAIL rst_restart: got %0d words first idx %0d, expected %0d words from 0",
                     got_data.size(), (got_idx.size() > 0) ? got_idx[0] : -1, OUT_N);
        end
        for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
            checks++;
            if (got_data[i] !== mem[i] || got_idx[i] != i) begin
                errors++;
                $display("FAIL rst_word[%0d]: got data=%h idx=%0d, expected data=%h idx=%0d", i, got_data[i], got_idx[i], mem[i], i);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            int dly;
            dly = 200 + 100 * r + int'($urandom_range(0, 50));
            fill_mem();
            done_delay = dly; conv_cycles = 32'(dly);
            run_stream(2 * r, -1, 3000);
            checks++;
            if (cycles_latched !== 32'(dly)) begin errors++; $display("FAIL b2b[%0d]_cycles_latched: got %0d, expected %0d", r, cycles_latched, dly); end
            checks++;
            if (fin_cnt != 1 || stall_viol != 0) begin errors++; $display("FAIL b2b[%0d]_fin_stable: got fin=%0d viol=%0d, expected 1 0", r, fin_cnt, stall_viol); end
            checks++;
            if (got_data.size() != OUT_N) begin errors++; $display("FAIL b2b[%0d]_word_count: got %0d, expected %0d", r, got_data.size(), OUT_N); end
            for (int i = 0; i < got_data.size() && i < OUT_N; i++) begin
                checks++;
                if (got_data[i] !== mem[i] || got_idx[i] != i || got_last[i] !== (i == OUT_N - 1)) begin
                    errors++;
                    $display("FAIL b2b[%0d]_word[%0d]: got data=%h idx=%0d last=%b, expected data=%h idx=%0d", r, i, got_data[i], got_idx[i], got_last[i], mem[i], i);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0; m_ready = 1'b1; conv_cycles = '0;
        t_req = 1'b0; t_m_ready = 1'b1; t_conv_done = 1'b0; t_conv_cycles = '0; t_rd_data = '0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_backpressure();
        test_req_while_busy();
        test_timeout();
        test_reset_mid_stream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
